// File: rtl/dmem_pkg.sv
// dmem_pkg: shared states, funct3/lane-mask constants and width decode for the data-memory responder.
package dmem_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_e;
   localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
   localparam logic [3:0] MASK_B = 4'b0001, MASK_H = 4'b0011, MASK_W = 4'b1111;
   localparam int CNT_W = 4;
   // funct3 alone decides access width; anything unrecognised is a word
   function automatic logic [3:0] width_mask(input logic [2:0] f3);
      return (f3 == F3_B || f3 == F3_BU) ? MASK_B : (f3 == F3_H || f3 == F3_HU) ? MASK_H : MASK_W;
   endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: MEM-stage load/store request and response bundle.
interface data_mem_responder_if;
   logic [3:0]  mem_read;
   logic [3:0]  mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        err;
   modport master (output mem_read, mem_write, funct3, addr, wdata, input stall, resp_valid, rdata, err);
   modport slave (input mem_read, mem_write, funct3, addr, wdata, output stall, resp_valid, rdata, err);
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, store-data shift, misalign detect and load extension.
module dmem_lane_align import dmem_pkg::*; (
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] raw,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic        misalign,
   output logic [31:0] ldata
);
   logic [3:0]  wmask;
   logic [31:0] sh;
   logic        sx;
   always_comb begin
      wmask = width_mask(funct3);
      be = wmask << offset;
      misalign = (wmask == MASK_H && offset[0]) || (wmask == MASK_W && offset != 2'b00);
      wdata_sh = wdata << {offset, 3'b000};
      sh = raw >> {offset, 3'b000};
      sx = ~funct3[2];
      ldata = wmask == MASK_B ? {{24{sx & sh[7]}}, sh[7:0]} :
              wmask == MASK_H ? {{16{sx & sh[15]}}, sh[15:0]} : sh;
   end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state SRAM responder for RV32 loads/stores with pipeline stall.
module data_mem_responder import dmem_pkg::*; #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input logic clk,
  input logic rst_n,
  data_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  dmem_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cap_read, cap_write;
  logic [2:0]       cap_f3;
  logic [31:0]      cap_addr, cap_wdata;
  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wdata_sh, ldata;
  logic             misalign, in_range, conflict, fault, access, req;
  dmem_lane_align u_align (
    .offset(cap_addr[1:0]), .funct3(cap_f3), .wdata(cap_wdata), .raw(mem[idx]),
    .be(be), .wdata_sh(wdata_sh), .misalign(misalign), .ldata(ldata)
  );
  always_comb begin
    req = |bus.mem_read || |bus.mem_write;
    idx = cap_addr[IDX_W+1:2];
    in_range = cap_addr[31:2] < 30'(DEPTH_WORDS);
    conflict = |cap_read && |cap_write;
    fault = misalign || !in_range || conflict;
    access = state == BUSY && cnt == '0;
    bus.stall = state == BUSY || (state == IDLE && req);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      cap_read <= '0;
      cap_write <= '0;
      cap_f3 <= '0;
      cap_addr <= '0;
      cap_wdata <= '0;
      bus.resp_valid <= 1'b0;
      bus.rdata <= '0;
      bus.err <= 1'b0;
    end else begin
      state <= state == IDLE ? (req ? BUSY : IDLE) : state == BUSY ? (access ? DONE : BUSY) : IDLE;
      cnt <= state == IDLE ? CNT_W'(WAIT_STATES) : cnt == '0 ? cnt : cnt - 1'b1;
      if (state == IDLE && req) begin
        cap_read <= bus.mem_read;
        cap_write <= bus.mem_write;
        cap_f3 <= bus.funct3;
        cap_addr <= bus.addr;
        cap_wdata <= bus.wdata;
      end
      bus.resp_valid <= access;
      bus.rdata <= access && |cap_read && !fault ? ldata : '0;
      bus.err <= access && fault;
    end
  always_ff @(posedge clk)
    if (access && |cap_write && !fault)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of latency, lane handling and error cases
// on a 2-wait-state instance and a 0-wait-state instance.
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   logic [31:0] r;
   logic e;
   int lat, stl;

   data_mem_responder_if b0();
   data_mem_responder_if b1();
   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv(input bit u, input logic [3:0] rd, input logic [3:0] wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
      if (u) begin
         b1.mem_read = rd; b1.mem_write = wr; b1.funct3 = f3; b1.addr = a; b1.wdata = wd;
      end else begin
         b0.mem_read = rd; b0.mem_write = wr; b0.funct3 = f3; b0.addr = a; b0.wdata = wd;
      end
   endtask

   // drive one request, count stalled cycles until resp_valid, then release and idle one cycle
   task automatic acc(input bit u, input logic [3:0] rd, input logic [3:0] wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rdat, output logic er, output int lt, output int st);
      drv(u, rd, wr, f3, a, wd);
      lt = 0;
      st = 0;
      #1;
      while (!(u ? b1.resp_valid : b0.resp_valid) && lt < 40) begin
         if (u ? b1.stall : b0.stall) st++;
         @(posedge clk); #1;
         lt++;
      end
      chk("resp_timeout", 32'(lt < 40), 32'd1);
      rdat = u ? b1.rdata : b0.rdata;
      er = u ? b1.err : b0.err;
      chk("stall_in_done", 32'(u ? b1.stall : b0.stall), 32'd0);
      drv(u, 4'h0, 4'h0, 3'b000, 32'h0, 32'h0);
      @(posedge clk); #1;
      chk("rdata_idle", u ? b1.rdata : b0.rdata, 32'h0);
   endtask

   initial begin
      drv(0, 4'h0, 4'h0, 3'b000, 32'h0, 32'h0);
      drv(1, 4'h0, 4'h0, 3'b000, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", 32'(b0.stall), 32'd0);
      chk("rst_resp", 32'(b0.resp_valid), 32'd0);
      chk("rst_rdata", b0.rdata, 32'h0);
      chk("rst_err", 32'(b0.err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // reset in the middle of a store must drop it
      acc(0, 4'h0, 4'hF, 3'b010, 32'h10, 32'h11111111, r, e, lat, stl);
      drv(0, 4'h0, 4'hF, 3'b010, 32'h10, 32'h22222222);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midbusy_stall", 32'(b0.stall), 32'd1);
      rst_n = 1'b0;
      drv(0, 4'h0, 4'h0, 3'b000, 32'h0, 32'h0);
      @(posedge clk); #1;
      chk("abort_stall", 32'(b0.stall), 32'd0);
      chk("abort_resp", 32'(b0.resp_valid), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      acc(0, 4'hF, 4'h0, 3'b010, 32'h10, 32'h0, r, e, lat, stl);
      chk("abort_word", r, 32'h11111111);

      // word store/load with two wait states
      acc(0, 4'h0, 4'hF, 3'b010, 32'h20, 32'hDEADBEEF, r, e, lat, stl);
      chk("sw_latency", 32'(lat), 32'd4);
      chk("sw_stall_cycles", 32'(stl), 32'd4);
      chk("sw_err", 32'(e), 32'd0);
      chk("sw_rdata", r, 32'h0);
      acc(0, 4'hF, 4'h0, 3'b010, 32'h20, 32'h0, r, e, lat, stl);
      chk("lw", r, 32'hDEADBEEF);

      // byte lanes and sign/zero extension
      acc(0, 4'h0, 4'h1, 3'b000, 32'h23, 32'h00000080, r, e, lat, stl);
      acc(0, 4'h1, 4'h0, 3'b000, 32'h23, 32'h0, r, e, lat, stl);
      chk("lb", r, 32'hFFFFFF80);
      acc(0, 4'h1, 4'h0, 3'b100, 32'h23, 32'h0, r, e, lat, stl);
      chk("lbu", r, 32'h00000080);
      acc(0, 4'hF, 4'h0, 3'b010, 32'h20, 32'h0, r, e, lat, stl);
      chk("sb_intact", r, 32'h80ADBEEF);
      acc(0, 4'h0, 4'h1, 3'b000, 32'h21, 32'h00000077, r, e, lat, stl);
      acc(0, 4'h1, 4'h0, 3'b100, 32'h21, 32'h0, r, e, lat, stl);
      chk("lbu_off1", r, 32'h00000077);

      // halfwords
      acc(0, 4'h0, 4'hF, 3'b010, 32'h20, 32'h80011234, r, e, lat, stl);
      acc(0, 4'h3, 4'h0, 3'b001, 32'h22, 32'h0, r, e, lat, stl);
      chk("lh_hi", r, 32'hFFFF8001);
      acc(0, 4'h3, 4'h0, 3'b101, 32'h22, 32'h0, r, e, lat, stl);
      chk("lhu_hi", r, 32'h00008001);
      acc(0, 4'h3, 4'h0, 3'b001, 32'h20, 32'h0, r, e, lat, stl);
      chk("lh_lo", r, 32'h00001234);
      acc(0, 4'h3, 4'h0, 3'b001, 32'h21, 32'h0, r, e, lat, stl);
      chk("lh_mis_err", 32'(e), 32'd1);
      chk("lh_mis_rdata", r, 32'h0);
      acc(0, 4'h0, 4'h3, 3'b001, 32'h21, 32'h0000FFFF, r, e, lat, stl);
      chk("sh_mis_err", 32'(e), 32'd1);
      acc(0, 4'hF, 4'h0, 3'b011, 32'h20, 32'h0, r, e, lat, stl);
      chk("sh_mis_nowrite", r, 32'h80011234);

      // range and conflict errors
      acc(0, 4'h0, 4'hF, 3'b010, 32'h0, 32'hA5A5A5A5, r, e, lat, stl);
      acc(0, 4'h0, 4'hF, 3'b010, 32'h1000, 32'h5A5A5A5A, r, e, lat, stl);
      chk("range_err", 32'(e), 32'd1);
      acc(0, 4'hF, 4'h0, 3'b010, 32'h0, 32'h0, r, e, lat, stl);
      chk("range_nowrite", r, 32'hA5A5A5A5);
      acc(0, 4'h0, 4'hF, 3'b010, 32'hFFC, 32'h0BADF00D, r, e, lat, stl);
      chk("last_word_err", 32'(e), 32'd0);
      acc(0, 4'hF, 4'h0, 3'b010, 32'hFFC, 32'h0, r, e, lat, stl);
      chk("last_word", r, 32'h0BADF00D);
      acc(0, 4'hF, 4'hF, 3'b010, 32'h20, 32'h0, r, e, lat, stl);
      chk("conflict_err", 32'(e), 32'd1);
      chk("conflict_rdata", r, 32'h0);
      acc(0, 4'hF, 4'h0, 3'b010, 32'h20, 32'h0, r, e, lat, stl);
      chk("conflict_nowrite", r, 32'h80011234);

      // zero wait states, back-to-back loads
      acc(1, 4'h0, 4'hF, 3'b010, 32'h4, 32'h11223344, r, e, lat, stl);
      chk("ws0_latency", 32'(lat), 32'd2);
      chk("ws0_stall_cycles", 32'(stl), 32'd2);
      acc(1, 4'h0, 4'hF, 3'b010, 32'h8, 32'hCAFEF00D, r, e, lat, stl);
      drv(1, 4'hF, 4'h0, 3'b010, 32'h4, 32'h0);
      #1;
      chk("b2b_n_stall", 32'(b1.stall), 32'd1);
      @(posedge clk); #1;
      chk("b2b_n1_stall", 32'(b1.stall), 32'd1);
      chk("b2b_n1_resp", 32'(b1.resp_valid), 32'd0);
      @(posedge clk); #1;
      chk("b2b_n2_resp", 32'(b1.resp_valid), 32'd1);
      chk("b2b_n2_stall", 32'(b1.stall), 32'd0);
      chk("b2b_n2_rdata", b1.rdata, 32'h11223344);
      drv(1, 4'hF, 4'h0, 3'b010, 32'h8, 32'h0);
      @(posedge clk); #1;
      chk("b2b_n3_stall", 32'(b1.stall), 32'd1);
      chk("b2b_n3_resp", 32'(b1.resp_valid), 32'd0);
      @(posedge clk); #1;
      chk("b2b_n4_stall", 32'(b1.stall), 32'd1);
      @(posedge clk); #1;
      chk("b2b_n5_resp", 32'(b1.resp_valid), 32'd1);
      chk("b2b_n5_stall", 32'(b1.stall), 32'd0);
      chk("b2b_n5_rdata", b1.rdata, 32'hCAFEF00D);
      drv(1, 4'h0, 4'h0, 3'b000, 32'h0, 32'h0);
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
